// File: rtl/reg_file_pkg.sv
// Shared types and default parameter values for the reg_file_sb register file.
package reg_file_pkg;

  // Post-reset clear sequence, then normal operation.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  localparam int DATA_W_D   = 32;
  localparam int ADDR_W_D   = 5;
  localparam int TRIG_REG_D = 5;
  localparam int OUT_REG_D  = 10;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by an issuing load
// and cleared by the matching writeback. x0 is never busy.
module reg_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [ADDR_W-1:0] SA,
  input  logic              SE,
  input  logic [ADDR_W-1:0] A3,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic              busy1,
  output logic              busy2
);

  localparam int NREGS = 2**ADDR_W;

  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign set_vec[gi]   = 1'b0;
        assign clr_vec[gi]   = run && WE3 && (A3 == '0);
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        assign set_vec[gi]   = run && SE && (SA == ADDR_W'(gi));
        assign clr_vec[gi]   = run && WE3 && (A3 == ADDR_W'(gi));
        // A new load to the same rd outranks the writeback of the old one.
        assign busy_next[gi] = set_vec[gi] | (busy_reg[gi] & ~clr_vec[gi]);
      end
    end
  endgenerate

  // Busy vector register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  // Lookup; with bypass a register being written back this cycle is already free.
  always_comb begin
    busy1 = run && busy_reg[A1] && !((BYPASS != 0) && clr_vec[A1]);
    busy2 = run && busy_reg[A2] && !((BYPASS != 0) && clr_vec[A2]);
  end

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with post-reset clear, optional write bypass,
// load-use scoreboard and a trigger input mapped onto one register.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W      = DATA_W_D,
  parameter int ADDR_W      = ADDR_W_D,
  parameter int TRIG_REG    = TRIG_REG_D,
  parameter int OUT_REG     = OUT_REG_D,
  parameter int BYPASS      = 1,
  parameter int TRIG_STICKY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] SA,
  input  logic              SE,
  input  logic              trigger,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              busy1,
  output logic              busy2,
  output logic [DATA_W-1:0] a0,
  output logic              init_done
);

  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] TRIG_A = ADDR_W'(TRIG_REG);
  localparam logic [ADDR_W-1:0] OUT_A  = ADDR_W'(OUT_REG);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NREGS - 1);

  rf_state_t         state_reg;
  rf_state_t         state_next;
  logic [ADDR_W-1:0] idx_reg;
  logic [ADDR_W-1:0] idx_next;

  logic [DATA_W-1:0] mem [NREGS];

  logic              run;
  logic              wr_ok;
  logic [DATA_W-1:0] trig_word;

  assign run       = (state_reg == RUN);
  assign init_done = run;
  // CPU writes to x0 and to the trigger register are dropped.
  assign wr_ok     = run && WE3 && (A3 != '0) && (A3 != TRIG_A);

  // Clear FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= CLEAR;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // Clear FSM next state: walk every index once, then run.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      CLEAR: begin
        idx_next = idx_reg + 1'b1;
        if (idx_reg == LAST_A) begin
          state_next = RUN;
        end
      end
      RUN: begin
        idx_next = idx_reg;
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  generate
    if (TRIG_STICKY != 0) begin : g_sticky
      logic trig_prev_reg;
      logic trig_latch_reg;
      logic trig_latch_next;
      logic trig_rise;
      logic trig_clr;

      assign trig_rise = trigger && !trig_prev_reg;
      assign trig_clr  = run && WE3 && (A3 == TRIG_A) && !WD3[0];

      // Latch update: a fresh rising edge beats a software clear.
      always_comb begin
        trig_latch_next = trig_latch_reg;
        if (trig_rise) begin
          trig_latch_next = 1'b1;
        end else if (trig_clr) begin
          trig_latch_next = 1'b0;
        end
      end

      // Edge detector and latch registers.
      always_ff @(posedge clk) begin
        if (rst) begin
          trig_prev_reg  <= 1'b0;
          trig_latch_reg <= 1'b0;
        end else begin
          trig_prev_reg <= trigger;
          if (run) begin
            trig_latch_reg <= trig_latch_next;
          end
        end
      end

      assign trig_word = {{(DATA_W-1){1'b0}}, trig_latch_next};
    end else begin : g_level
      assign trig_word = {{(DATA_W-1){1'b0}}, trigger};
    end
  endgenerate

  // Storage: sequential clear, then CPU writes plus the trigger mirror.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_reg == CLEAR) begin
        mem[idx_reg] <= '0;
      end else begin
        if (wr_ok) begin
          mem[A3] <= WD3;
        end
        mem[TRIG_A] <= trig_word;
      end
    end
  end

  // Read ports with optional same-cycle write bypass; all zero while clearing.
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (run && (A1 != '0)) begin
      if ((BYPASS != 0) && wr_ok && (A3 == A1)) begin
        RD1 = WD3;
      end else begin
        RD1 = mem[A1];
      end
    end
    if (run && (A2 != '0)) begin
      if ((BYPASS != 0) && wr_ok && (A3 == A2)) begin
        RD2 = WD3;
      end else begin
        RD2 = mem[A2];
      end
    end
  end

  assign a0 = run ? mem[OUT_A] : '0;

  reg_scoreboard #(
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .SA    (SA),
    .SE    (SE),
    .A3    (A3),
    .WE3   (WE3),
    .A1    (A1),
    .A2    (A2),
    .busy1 (busy1),
    .busy2 (busy2)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench: a default instance (bypass, level trigger) and a
// BYPASS=0 / sticky-trigger instance driven by the same stimulus.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  a1 = '0, a2 = '0, a3 = '0, sa = '0;
  logic [31:0] wd3 = '0;
  logic        we3 = 1'b0, se = 1'b0, trigger = 1'b0;

  logic [31:0] rd1, rd2, a0;
  logic        busy1, busy2, init_done;
  logic [31:0] s_rd1, s_rd2, s_a0;
  logic        s_busy1, s_busy2, s_init_done;

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk(clk), .rst(rst), .A1(a1), .A2(a2), .A3(a3), .WD3(wd3), .WE3(we3),
    .SA(sa), .SE(se), .trigger(trigger), .RD1(rd1), .RD2(rd2),
    .busy1(busy1), .busy2(busy2), .a0(a0), .init_done(init_done)
  );

  reg_file_sb #(.BYPASS(0), .TRIG_STICKY(1)) dut_s (
    .clk(clk), .rst(rst), .A1(a1), .A2(a2), .A3(a3), .WD3(wd3), .WE3(we3),
    .SA(sa), .SE(se), .trigger(trigger), .RD1(s_rd1), .RD2(s_rd2),
    .busy1(s_busy1), .busy2(s_busy2), .a0(s_a0), .init_done(s_init_done)
  );

  localparam int S_RD1 = 0, S_RD2 = 1, S_B1 = 2, S_B2 = 3, S_A0 = 4, S_INIT = 5;
  localparam int S_SRD1 = 6, S_SB1 = 7, S_SA0 = 8, S_SINIT = 9, S_SRD2 = 10, S_SB2 = 11;

  typedef struct {
    string       nm;
    int          sig;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        s_en;
    logic [4:0]  s_addr;
    logic        trig;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic        e_b1;
    logic        e_b2;
    logic [31:0] e_srd1;
    logic        e_sb1;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[18];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   n_txn = 0;

  function automatic logic [31:0] cur(input int sig);
    case (sig)
      S_RD1:   return rd1;
      S_RD2:   return rd2;
      S_B1:    return {31'd0, busy1};
      S_B2:    return {31'd0, busy2};
      S_A0:    return a0;
      S_INIT:  return {31'd0, init_done};
      S_SRD1:  return s_rd1;
      S_SB1:   return {31'd0, s_busy1};
      S_SA0:   return s_a0;
      S_SINIT: return {31'd0, s_init_done};
      S_SRD2:  return s_rd2;
      S_SB2:   return {31'd0, s_busy2};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [4:0] ra1, input logic [4:0] ra2,
                              input logic s_en, input logic [4:0] s_addr, input logic trig,
                              input logic [31:0] e_rd1, input logic [31:0] e_rd2,
                              input logic e_b1, input logic e_b2,
                              input logic [31:0] e_srd1, input logic e_sb1);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ra1 = ra1; v.ra2 = ra2;
    v.s_en = s_en; v.s_addr = s_addr; v.trig = trig;
    v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_b1 = e_b1; v.e_b2 = e_b2;
    v.e_srd1 = e_srd1; v.e_sb1 = e_sb1;
    return v;
  endfunction

  task automatic push(input string nm, input int sig, input logic [31:0] v);
    exp_t e;
    e.nm = nm;
    e.sig = sig;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra1, input logic [4:0] ra2,
                       input logic s_en, input logic [4:0] s_addr, input logic trig);
    we3 = we; a3 = wa; wd3 = wd; a1 = ra1; a2 = ra2; se = s_en; sa = s_addr; trigger = trig;
  endtask

  // Sample away from the edge, drain the scoreboard, then advance one clock.
  task automatic cycle(input string tag);
    exp_t        e;
    logic [31:0] act;
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      act = cur(e.sig);
      n_cmp++;
      if (act !== e.val) begin
        n_mis++;
        $display("FAIL %s/%s: got %h expected %h", tag, e.nm, act, e.val);
      end
    end
    n_txn++;
    $display("txn %0d %s: rst=%b we=%b a3=%0d wd=%h a1=%0d a2=%0d se=%b sa=%0d trig=%b | rd1=%h rd2=%h b=%b%b a0=%h init=%b | s_rd1=%h s_b1=%b",
             n_txn, tag, rst, we3, a3, wd3, a1, a2, se, sa, trigger, rd1, rd2, busy1, busy2,
             a0, init_done, s_rd1, s_busy1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    logic [31:0] seq_rd [5];
    logic [31:0] seq_srd [5];
    logic        seq_trig [5];

    // we a3 wd a1 a2 se sa trig | rd1 rd2 b1 b2 | srd1 sb1
    vecs[0]  = mk(1, 7, 32'hDEADBEEF, 7, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 7, 7, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0);
    vecs[2]  = mk(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 5, 32'h1234, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 5, 5, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    vecs[5]  = mk(0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[6]  = mk(0, 0, 0, 9, 9, 1, 9, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 9, 9, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    vecs[8]  = mk(1, 9, 32'h99, 9, 9, 0, 0, 0, 32'h99, 32'h99, 0, 0, 0, 1);
    vecs[9]  = mk(0, 0, 0, 9, 9, 0, 0, 0, 32'h99, 32'h99, 0, 0, 32'h99, 0);
    vecs[10] = mk(1, 9, 32'hAA, 9, 0, 1, 9, 0, 32'hAA, 0, 0, 0, 32'h99, 0);
    vecs[11] = mk(0, 0, 0, 9, 0, 0, 0, 0, 32'hAA, 0, 1, 0, 32'hAA, 1);
    vecs[12] = mk(1, 5, 0, 5, 9, 0, 0, 0, 0, 32'hAA, 0, 1, 1, 0);
    vecs[13] = mk(0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[16] = mk(1, 5, 32'h1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[17] = mk(0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // First reset and clear, bounded wait for init_done.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (init_done === 1'b1 && s_init_done === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_mis++;
      $display("FAIL first_clear: init_done=%b s_init_done=%b, required 1 within 40 cycles", init_done, s_init_done);
    end
    @(posedge clk);
    #1;

    // Preload; a0 follows a write to reg 10 one cycle later.
    drive(1, 7, 32'h11111111, 0, 0, 0, 0, 0);
    push("a0_pre", S_A0, 0); push("s_a0_pre", S_SA0, 0);
    cycle("preload7");
    drive(1, 10, 32'hA5, 7, 0, 0, 0, 0);
    push("rd1_r7", S_RD1, 32'h11111111); push("s_rd1_r7", S_SRD1, 32'h11111111);
    push("a0_wrcyc", S_A0, 0); push("s_a0_wrcyc", S_SA0, 0);
    cycle("preload10");
    drive(1, 3, 32'h33, 10, 0, 0, 0, 0);
    push("a0_next", S_A0, 32'hA5); push("s_a0_next", S_SA0, 32'hA5); push("rd1_r10", S_RD1, 32'hA5);
    cycle("preload3");
    drive(0, 0, 0, 3, 0, 0, 0, 0);
    push("rd1_r3", S_RD1, 32'h33); push("s_rd1_r3", S_SRD1, 32'h33);
    cycle("read3");

    // Second reset: clear takes exactly 32 edges, outputs forced low, writes and SE ignored.
    drive(0, 0, 0, 7, 0, 0, 0, 0);
    rst = 1'b1;
    push("init_before_rst", S_INIT, 1); push("rd1_before_rst", S_RD1, 32'h11111111);
    cycle("rst");
    rst = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k == 5)       drive(1, 12, 32'h55, 7, 0, 1, 12, 0);
      else if (k == 31) drive(1, 3, 32'h77, 7, 0, 1, 3, 0);
      else              drive(0, 0, 0, 7, 0, 0, 0, 0);
      push($sformatf("init_clr%0d", k), S_INIT, 0);
      push($sformatf("a0_clr%0d", k), S_A0, 0);
      push($sformatf("rd1_clr%0d", k), S_RD1, 0);
      if (k == 2 || k == 31) push($sformatf("s_a0_clr%0d", k), S_SA0, 0);
      cycle("clear");
    end
    drive(0, 0, 0, 12, 3, 0, 0, 0);
    push("init_after", S_INIT, 1); push("s_init_after", S_SINIT, 1);
    push("rd1_r12_after", S_RD1, 0); push("rd2_r3_after", S_RD2, 0);
    push("b1_r12_after", S_B1, 0); push("b2_r3_after", S_B2, 0);
    push("s_rd2_r3_after", S_SRD2, 0); push("s_b2_r3_after", S_SB2, 0);
    cycle("post_clear");
    drive(0, 0, 0, 7, 10, 0, 0, 0);
    push("rd1_r7_cleared", S_RD1, 0); push("rd2_r10_cleared", S_RD2, 0); push("a0_cleared", S_A0, 0);
    cycle("post_clear2");

    // Table-driven vectors.
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2,
            vecs[i].s_en, vecs[i].s_addr, vecs[i].trig);
      push($sformatf("v%0d_rd1", i), S_RD1, vecs[i].e_rd1);
      push($sformatf("v%0d_rd2", i), S_RD2, vecs[i].e_rd2);
      push($sformatf("v%0d_b1", i), S_B1, {31'd0, vecs[i].e_b1});
      push($sformatf("v%0d_b2", i), S_B2, {31'd0, vecs[i].e_b2});
      push($sformatf("v%0d_srd1", i), S_SRD1, vecs[i].e_srd1);
      push($sformatf("v%0d_sb1", i), S_SB1, {31'd0, vecs[i].e_sb1});
      cycle($sformatf("vec%0d", i));
    end

    // Trigger 0,1,1,0,0: level mirror lags one cycle; sticky latch holds after the rise.
    seq_trig[0] = 0; seq_trig[1] = 1; seq_trig[2] = 1; seq_trig[3] = 0; seq_trig[4] = 0;
    seq_rd[0] = 0;   seq_rd[1] = 0;   seq_rd[2] = 1;   seq_rd[3] = 1;   seq_rd[4] = 0;
    seq_srd[0] = 0;  seq_srd[1] = 0;  seq_srd[2] = 1;  seq_srd[3] = 1;  seq_srd[4] = 1;
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 5, 0, 0, 0, seq_trig[k]);
      push($sformatf("trig_lvl%0d", k), S_RD1, seq_rd[k]);
      push($sformatf("trig_stk%0d", k), S_SRD1, seq_srd[k]);
      cycle("trigseq");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
